// File: rtl/dso100fb_pkg.sv
// Shared encodings for the DSO100FB start/stop controller and its sequencer.
// Opcodes, sequencer states, IRQ bit positions and the controller FSM state type.
package dso100fb_pkg;

    localparam logic [1:0] SEQ_STOPPED  = 2'b00;
    localparam logic [1:0] SEQ_STARTING = 2'b01;
    localparam logic [1:0] SEQ_STARTED  = 2'b10;
    localparam logic [1:0] SEQ_STOPPING = 2'b11;

    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;

    localparam int IRQ_STARTED = 0;
    localparam int IRQ_STOPPED = 1;
    localparam int IRQ_TIMEOUT = 2;
    localparam int IRQ_CMD_ERR = 3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_WAIT_STOP  = 2'd2
    } ctrl_state_t;

    // One-hot mask for a single IRQ flag position.
    function automatic logic [3:0] irq_bit(input int idx);
        logic [3:0] v;
        v = '0;
        v[idx[1:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dso100fb_startstop_ctrl_if.sv
// Host command, sequencer and interrupt signals of the start/stop controller.
// Handshake: a command transfers on a rising CLK edge where CMD_VALID && CMD_READY; CMD_VALID is
// ignored while CMD_READY is low and nothing is queued.
interface dso100fb_startstop_ctrl_if;
    logic       CMD_VALID;
    logic [1:0] CMD_OP;
    logic       CMD_READY;
    logic       START;
    logic       STOP;
    logic       STARTED;
    logic       STOPPED;
    logic [1:0] SEQ_STATE;
    logic       BUSY;
    logic [3:0] IRQ_STATUS;
    logic [3:0] IRQ_MASK;
    logic [3:0] IRQ_CLEAR;
    logic       IRQ;

    modport master (
        output CMD_VALID, CMD_OP, STARTED, STOPPED, SEQ_STATE, IRQ_MASK, IRQ_CLEAR,
        input  CMD_READY, START, STOP, BUSY, IRQ_STATUS, IRQ
    );

    modport slave (
        input  CMD_VALID, CMD_OP, STARTED, STOPPED, SEQ_STATE, IRQ_MASK, IRQ_CLEAR,
        output CMD_READY, START, STOP, BUSY, IRQ_STATUS, IRQ
    );
endinterface

// File: rtl/dso100fb_timeout.sv
// Loadable down-counter; o_expire marks the enabled cycle on which the count reaches zero.
module dso100fb_timeout #(
    parameter int WIDTH = 24
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expire
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_expire = i_en && !i_load && (r_count == ONE);

endmodule

// File: rtl/dso100fb_startstop_ctrl.sv
// Start/stop command controller: validates host commands against the sequencer state, issues
// one-cycle START/STOP requests, waits for acknowledge with a timeout and keeps sticky IRQ flags.
module dso100fb_startstop_ctrl
    import dso100fb_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    dso100fb_startstop_ctrl_if.slave  bus,
    output ctrl_state_t               o_dbg_state
);
    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    logic        r_start;
    logic        r_stop;
    logic        w_start_nxt;
    logic        w_stop_nxt;
    logic [3:0]  r_status;
    logic [3:0]  w_set;
    logic        r_irq;
    logic        w_load;
    logic        w_cnt_en;
    logic        w_expire;
    logic        w_accept;

    assign w_accept = bus.CMD_VALID && (r_state == ST_IDLE);
    assign w_cnt_en = (r_state != ST_IDLE);

    dso100fb_timeout #(.WIDTH(24)) u_timeout (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .i_load     (w_load),
        .i_load_val (TIMEOUT_CYCLES),
        .i_en       (w_cnt_en),
        .o_expire   (w_expire)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_stop  <= w_stop_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 1'b0;
        w_stop_nxt  = 1'b0;
        w_load      = 1'b0;
        w_set       = '0;
        // Acknowledge flags record every pulse, including late ones after a timeout.
        if (bus.STARTED) w_set = w_set | irq_bit(IRQ_STARTED);
        if (bus.STOPPED) w_set = w_set | irq_bit(IRQ_STOPPED);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if ((bus.CMD_OP == OP_START) && (bus.SEQ_STATE == SEQ_STOPPED)) begin
                        w_state_nxt = ST_WAIT_START;
                        w_start_nxt = 1'b1;
                        w_load      = 1'b1;
                    end else if ((bus.CMD_OP == OP_STOP) && (bus.SEQ_STATE == SEQ_STARTED)) begin
                        w_state_nxt = ST_WAIT_STOP;
                        w_stop_nxt  = 1'b1;
                        w_load      = 1'b1;
                    end else begin
                        w_set = w_set | irq_bit(IRQ_CMD_ERR);
                    end
                end
            end
            ST_WAIT_START: begin
                // The acknowledge wins over a timeout expiring on the same cycle.
                if (bus.STARTED) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_set       = w_set | irq_bit(IRQ_TIMEOUT);
                end
            end
            ST_WAIT_STOP: begin
                if (bus.STOPPED) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_set       = w_set | irq_bit(IRQ_TIMEOUT);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Set beats clear on the same bit; clears of other bits still take effect.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~bus.IRQ_CLEAR) | w_set;
            r_irq    <= |(r_status & bus.IRQ_MASK);
        end
    end

    assign bus.CMD_READY  = (r_state == ST_IDLE);
    assign bus.BUSY       = (r_state != ST_IDLE);
    assign bus.START      = r_start;
    assign bus.STOP       = r_stop;
    assign bus.IRQ_STATUS = r_status;
    assign bus.IRQ        = r_irq;
    assign o_dbg_state    = r_state;

endmodule
